sargantana_icache_refill: RTL and testbench
===========================================

# sargantana_icache_refill

Refill writer for the instruction-cache data array. On a miss it captures the target set index and victim way, collects the line from the next memory level as fixed-width beats, and writes the assembled line into the selected way with a single write request. It drives the request, write-enable, address and data inputs of the per-way data memory and sits between the icache controller (miss side) and the data-memory ways.

## Interface
- ICACHE_N_WAY, 4, number of ways; width of one-hot way request
- SET_WIDHT, 256, line width in bits
- ADDR_WIDHT, 6, set-index width
- BEAT_WIDHT, 64, refill beat width; SET_WIDHT must be an integer multiple; N_BEATS = SET_WIDHT/BEAT_WIDHT (≥2)

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset, synchronous, active-low
- miss_valid_i  in  1  refill request
- miss_ready_o  out  1  request accepted when high with miss_valid_i
- miss_idx_i  in  ADDR_WIDHT  set index to refill
- miss_way_i  in  ICACHE_N_WAY  one-hot victim way
- kill_i  in  1  abort refill in progress
- beat_valid_i  in  1  beat present
- beat_ready_o  out  1  beat accepted when high with beat_valid_i
- beat_data_i  in  BEAT_WIDHT  beat payload
- mem_req_o  out  ICACHE_N_WAY  per-way request to data memory
- mem_we_o  out  1  write enable to data memory
- mem_addr_o  out  ADDR_WIDHT  set index to data memory
- mem_data_o  out  SET_WIDHT  assembled line
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse on line write

## Operation
- FSM states: IDLE, FILL, WRITE.
- IDLE: miss_ready_o=1. On miss_valid_i, register the index and way, clear the beat counter and go to FILL.
- FILL: beat_ready_o=1. Each accepted beat k (k = counter value) goes to line bits [(k+1)·BEAT_WIDHT-1 : k·BEAT_WIDHT], and the counter increments. When the beat with counter = N_BEATS-1 is accepted, go to WRITE. Gaps between beats are allowed; the counter holds.
- WRITE: for one cycle, mem_req_o = registered way, mem_we_o=1, mem_addr_o = registered index, done_o=1. Next state is IDLE.
- mem_req_o and mem_we_o are 0 outside WRITE. mem_addr_o and mem_data_o always reflect the registers.
- kill_i in FILL: go to IDLE next cycle with no write. A beat presented in the same cycle is discarded. kill_i in IDLE or WRITE is ignored, so a WRITE always completes.
- Beats presented outside FILL are not accepted (beat_ready_o=0).
- A miss_way_i that is not one-hot is forwarded unchanged. The caller is responsible for it.
- Line bits not yet written in the current refill keep their old contents. No clearing is done between refills.

## Timing
- Reset (rstn_i low at a clock edge): state becomes IDLE, counter and index/way/line registers become 0. After that edge, miss_ready_o=1 and beat_ready_o, mem_req_o, mem_we_o, busy_o, done_o are 0. mem_addr_o and mem_data_o are 0.
- A reset edge during FILL or WRITE aborts the refill and no write is issued.
- Miss accepted at cycle 0 → FILL from cycle 1. With back-to-back beats in cycles 1..N_BEATS, WRITE occurs at cycle N_BEATS+1 and miss_ready_o is high again at cycle N_BEATS+2.
- Minimum miss-to-miss spacing is N_BEATS+2 cycles. The data memory sees exactly one write per completed refill.

## Configuration
- SARGANTANA_ICACHE_REFILL_RR_VICTIM_EN defined: miss_way_i is ignored. The victim comes from an internal one-hot round-robin pointer that resets to way 0 and rotates by one position after each completed WRITE; a kill or reset mid-refill does not advance it. The pointer value is captured at miss acceptance.
- Not defined: the victim is the registered miss_way_i and no pointer exists.

## Test plan
- Basic refill (N_BEATS=4): miss idx=0x05, way=4'b0100, then beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back → at cycle 5: mem_req_o=4'b0100, mem_we_o=1, mem_addr_o=0x05, mem_data_o = {0x44..,0x33..,0x22..,0x11..}, done_o=1 for one cycle.
- Gapped beats: idle cycles between beats → same line as above; the write is delayed by the gap count.
- Kill after 2 beats → mem_we_o stays 0, busy_o=0 and miss_ready_o=1 next cycle. A following refill to idx=0x3F, way=4'b0001 writes the correct line.
- Kill asserted in the WRITE cycle → the write still occurs and done_o=1.
- Reset asserted mid-FILL → all outputs take their reset values and no write occurs. Beats presented afterwards are not accepted.
- With SARGANTANA_ICACHE_REFILL_RR_VICTIM_EN: five refills give mem_req_o = 0001, 0010, 0100, 1000, 0001. A killed refill in between does not advance the sequence.

Source files
------------

// File: rtl/sargantana_icache_refill.sv
// Instruction-cache refill writer: collects N_BEATS beats into one line, then writes it to the victim way.
// Optional macro SARGANTANA_ICACHE_REFILL_RR_VICTIM_EN selects an internal round-robin victim pointer.
module sargantana_icache_refill #(
   parameter int ICACHE_N_WAY = 4,
   parameter int SET_WIDHT    = 256,
   parameter int ADDR_WIDHT   = 6,
   parameter int BEAT_WIDHT   = 64
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    miss_valid_i,
   output logic                    miss_ready_o,
   input  logic [ADDR_WIDHT-1:0]   miss_idx_i,
   input  logic [ICACHE_N_WAY-1:0] miss_way_i,
   input  logic                    kill_i,
   input  logic                    beat_valid_i,
   output logic                    beat_ready_o,
   input  logic [BEAT_WIDHT-1:0]   beat_data_i,
   output logic [ICACHE_N_WAY-1:0] mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDHT-1:0]   mem_addr_o,
   output logic [SET_WIDHT-1:0]    mem_data_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int N_BEATS = SET_WIDHT / BEAT_WIDHT;
   localparam int CNT_W   = $clog2(N_BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CNT_W-1:0]        r_cnt;
   logic [ADDR_WIDHT-1:0]   r_idx;
   logic [ICACHE_N_WAY-1:0] r_way;
   logic [SET_WIDHT-1:0]    r_line;
   logic [ICACHE_N_WAY-1:0] w_victim;
   logic                    w_miss_acc;
   logic                    w_beat_acc;

   assign w_miss_acc = (r_state == IDLE) && miss_valid_i;
   // A beat arriving together with kill is dropped so the partial line is not extended.
   assign w_beat_acc = (r_state == FILL) && beat_valid_i && !kill_i;

`ifdef SARGANTANA_ICACHE_REFILL_RR_VICTIM_EN
   logic [ICACHE_N_WAY-1:0] r_rr_ptr;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_rr_ptr <= ICACHE_N_WAY'(1);
      end else if (r_state == WRITE) begin
         r_rr_ptr <= {r_rr_ptr[ICACHE_N_WAY-2:0], r_rr_ptr[ICACHE_N_WAY-1]};
      end
   end

   assign w_victim = r_rr_ptr;
`else
   assign w_victim = miss_way_i;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (miss_valid_i) w_state_nxt = FILL;
         FILL: begin
            if (kill_i)                                 w_state_nxt = IDLE;
            else if (beat_valid_i && r_cnt == LAST_BEAT) w_state_nxt = WRITE;
         end
         WRITE:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_way   <= '0;
         r_line  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_miss_acc) begin
            r_idx <= miss_idx_i;
            r_way <= w_victim;
            r_cnt <= '0;
         end
         if (w_beat_acc) begin
            r_cnt <= r_cnt + CNT_W'(1);
            for (int k = 0; k < N_BEATS; k++) begin
               if (r_cnt == CNT_W'(k)) r_line[k*BEAT_WIDHT +: BEAT_WIDHT] <= beat_data_i;
            end
         end
      end
   end

   assign miss_ready_o = (r_state == IDLE);
   assign beat_ready_o = (r_state == FILL);
   assign busy_o       = (r_state != IDLE);
   assign done_o       = (r_state == WRITE);
   assign mem_we_o     = (r_state == WRITE);
   assign mem_req_o    = (r_state == WRITE) ? r_way : '0;
   assign mem_addr_o   = r_idx;
   assign mem_data_o   = r_line;

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Directed plus randomized refills checked against a line/victim reference model.
module tb_sargantana_icache_refill;
   localparam int NW = 4;
   localparam int SW = 256;
   localparam int AW = 6;
   localparam int BW = 64;
   localparam int NB = SW / BW;

   logic          clk = 1'b0;
   logic          rstn_i = 1'b0;
   logic          miss_valid_i = 1'b0;
   logic          miss_ready_o;
   logic [AW-1:0] miss_idx_i = '0;
   logic [NW-1:0] miss_way_i = '0;
   logic          kill_i = 1'b0;
   logic          beat_valid_i = 1'b0;
   logic          beat_ready_o;
   logic [BW-1:0] beat_data_i = '0;
   logic [NW-1:0] mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [SW-1:0] mem_data_o;
   logic          busy_o;
   logic          done_o;

   sargantana_icache_refill #(
      .ICACHE_N_WAY(NW), .SET_WIDHT(SW), .ADDR_WIDHT(AW), .BEAT_WIDHT(BW)
   ) dut (
      .clk_i(clk), .rstn_i(rstn_i),
      .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
      .miss_idx_i(miss_idx_i), .miss_way_i(miss_way_i), .kill_i(kill_i),
      .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o), .beat_data_i(beat_data_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int wr_seen = 0;
   int wr_exp = 0;

   // Reference model: current line contents, refill target and round-robin victim index.
   logic [SW-1:0] m_line = '0;
   logic [AW-1:0] m_idx = '0;
   logic [NW-1:0] m_way = '0;
   int            m_rr = 0;

   always @(negedge clk) if (mem_we_o === 1'b1) wr_seen++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_miss_ready"}, miss_ready_o, 1);
      chk({tag, "_beat_ready"}, beat_ready_o, 0);
      chk({tag, "_req"}, mem_req_o, 0);
      chk({tag, "_we"}, mem_we_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_addr"}, mem_addr_o, 0);
      chk({tag, "_data"}, mem_data_o, 0);
   endtask

   task automatic do_miss(input logic [AW-1:0] idx, input logic [NW-1:0] way);
      chk("miss_ready_idle", miss_ready_o, 1);
      miss_valid_i = 1'b1;
      miss_idx_i   = idx;
      miss_way_i   = way;
      kill_i       = 1'($urandom_range(0, 1));
      tick();
      miss_valid_i = 1'b0;
      kill_i       = 1'b0;
      miss_idx_i   = AW'($urandom);
      miss_way_i   = NW'($urandom);
      m_idx = idx;
`ifdef SARGANTANA_ICACHE_REFILL_RR_VICTIM_EN
      m_way = NW'(1 << m_rr);
`else
      m_way = way;
`endif
      chk("fill_busy", busy_o, 1);
      chk("fill_beat_ready", beat_ready_o, 1);
      chk("fill_miss_ready", miss_ready_o, 0);
      chk("fill_addr", mem_addr_o, m_idx);
   endtask

   task automatic do_refill(input logic [AW-1:0] idx, input logic [NW-1:0] way, input bit directed,
                            input int kill_at, input int max_gap, input bit kill_in_write);
      logic [BW-1:0] data;
      do_miss(idx, way);
      for (int k = 0; k < NB; k++) begin
         repeat ($urandom_range(0, max_gap)) begin
            beat_valid_i = 1'b0;
            beat_data_i  = {$urandom, $urandom};
            tick();
            chk("gap_we", mem_we_o, 0);
            chk("gap_data", mem_data_o, m_line);
         end
         data = directed ? {8{8'(8'h11 * (k + 1))}} : {$urandom, $urandom};
         beat_valid_i = 1'b1;
         beat_data_i  = data;
         if (k == kill_at) begin
            kill_i = 1'b1;
            tick();
            beat_valid_i = 1'b0;
            kill_i       = 1'b0;
            chk("kill_busy", busy_o, 0);
            chk("kill_miss_ready", miss_ready_o, 1);
            chk("kill_we", mem_we_o, 0);
            chk("kill_data", mem_data_o, m_line);
            return;
         end
         m_line[k*BW +: BW] = data;
         tick();
         beat_valid_i = 1'b0;
      end
      kill_i = kill_in_write;
      chk("write_req", mem_req_o, m_way);
      chk("write_we", mem_we_o, 1);
      chk("write_addr", mem_addr_o, m_idx);
      chk("write_data", mem_data_o, m_line);
      chk("write_done", done_o, 1);
      chk("write_beat_ready", beat_ready_o, 0);
      wr_exp++;
      tick();
      kill_i = 1'b0;
      m_rr = (m_rr + 1) % NW;
      chk("after_done", done_o, 0);
      chk("after_we", mem_we_o, 0);
      chk("after_req", mem_req_o, 0);
      chk("after_busy", busy_o, 0);
      chk("after_miss_ready", miss_ready_o, 1);
   endtask

   initial begin
      tick();
      chk_reset_outputs("reset");
      rstn_i = 1'b1;

      beat_valid_i = 1'b1;
      beat_data_i  = {$urandom, $urandom};
      tick();
      chk("idle_beat_ready", beat_ready_o, 0);
      chk("idle_beat_data", mem_data_o, m_line);
      beat_valid_i = 1'b0;

      do_refill(6'h05, 4'b0100, 1'b1, -1, 0, 1'b0);
      do_refill(6'h05, 4'b0100, 1'b1, -1, 3, 1'b0);
      do_refill(6'h2A, 4'b0010, 1'b0, 2, 1, 1'b0);
      do_refill(6'h3F, 4'b0001, 1'b0, -1, 0, 1'b0);
      do_refill(6'h11, 4'b1000, 1'b0, -1, 1, 1'b1);

      for (int i = 0; i < 5; i++) begin
         do_refill(AW'($urandom), NW'(1 << i % NW), 1'b0, -1, 0, 1'b0);
         if (i == 2) do_refill(AW'($urandom), 4'b0010, 1'b0, 1, 0, 1'b0);
      end

      do_miss(6'h1C, 4'b0010);
      for (int k = 0; k < 2; k++) begin
         beat_valid_i = 1'b1;
         beat_data_i  = {$urandom, $urandom};
         m_line[k*BW +: BW] = beat_data_i;
         tick();
      end
      beat_valid_i = 1'b0;
      rstn_i = 1'b0;
      tick();
      m_line = '0;
      m_idx  = '0;
      m_rr   = 0;
      chk_reset_outputs("midfill_reset");
      rstn_i = 1'b1;
      repeat (2) begin
         beat_valid_i = 1'b1;
         beat_data_i  = {$urandom, $urandom};
         tick();
         chk("post_reset_beat_ready", beat_ready_o, 0);
         chk("post_reset_busy", busy_o, 0);
         chk("post_reset_data", mem_data_o, 0);
      end
      beat_valid_i = 1'b0;

      for (int i = 0; i < 20; i++) begin
         do_refill(AW'($urandom), NW'($urandom), 1'b0, int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      chk("write_count", 32'(wr_seen), 32'(wr_exp));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
